// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5-9 data bits, none/odd/even parity, 1-2 stop bits.
// Synchronised input, 3-sample mid-bit majority vote, parity/framing/break flags.
module uart_rx_cfg #(
  parameter int p_CLKs_PB   = 217,
  parameter int p_DATA_BITS = 8,
  parameter int p_PARITY    = 0,
  parameter int p_STOP_BITS = 1
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_n,
  input  logic                   i_Rx_UART,
  output logic                   o_Rx_Valid,
  output logic [p_DATA_BITS-1:0] o_Rx_Byte,
  output logic                   o_Parity_Err,
  output logic                   o_Frame_Err,
  output logic                   o_Break
);
  localparam int c_H  = (p_CLKs_PB - 1) / 2;
  localparam int c_CW = $clog2(p_CLKs_PB);
  localparam int c_IW = $clog2(p_DATA_BITS);

  localparam logic [c_CW-1:0] c_SMP0 = c_CW'(c_H - 1);
  localparam logic [c_CW-1:0] c_SMP1 = c_CW'(c_H);
  localparam logic [c_CW-1:0] c_SMP2 = c_CW'(c_H + 1);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(p_CLKs_PB - 1);
  localparam logic [c_IW-1:0] c_LAST_DATA = c_IW'(p_DATA_BITS - 1);
  localparam logic [c_IW-1:0] c_LAST_STOP = c_IW'(p_STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} t_state;

  t_state                 r_state, w_state_nx;
  logic                   r_sync1, r_sync2, w_rx;
  logic [c_CW-1:0]        r_cnt, w_cnt_nx;
  logic [c_IW-1:0]        r_idx, w_idx_nx;
  logic [p_DATA_BITS-1:0] r_shift, w_shift_nx;
  logic                   r_arm, w_arm_nx;
  logic                   r_smp0, r_smp1, w_vote;
  logic                   r_par_bit, w_par_bit_nx;
  logic                   r_stop_zero, w_stop_zero_nx;
  logic                   r_stop_one, w_stop_one_nx;
  logic                   w_cnt_end, w_at_vote, w_ones_odd;
  logic                   w_done, w_perr, w_ferr, w_brk;
  logic                   r_valid, r_perr, r_ferr, r_brk;
  logic [p_DATA_BITS-1:0] r_byte;

  assign w_rx      = r_sync2;
  assign w_vote    = (r_smp0 & r_smp1) | (r_smp0 & w_rx) | (r_smp1 & w_rx);
  assign w_cnt_end = (r_cnt == c_LAST);
  assign w_at_vote = (r_cnt == c_SMP2);

  // Evaluated in the final-stop vote cycle; the vote itself stands in for the last stop bit.
  assign w_ones_odd = ^{r_shift, r_par_bit};
  assign w_perr = (p_PARITY == 1) ? ~w_ones_odd : (p_PARITY == 2) ? w_ones_odd : 1'b0;
  assign w_ferr = r_stop_zero | ~w_vote;
  assign w_brk  = (r_shift == '0) & ~r_par_bit & ~r_stop_one & ~w_vote;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_smp0      <= 1'b0;
      r_smp1      <= 1'b0;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_arm       <= 1'b0;
      r_par_bit   <= 1'b0;
      r_stop_zero <= 1'b0;
      r_stop_one  <= 1'b0;
    end else begin
      r_sync1     <= i_Rx_UART;
      r_sync2     <= r_sync1;
      if (r_cnt == c_SMP0) r_smp0 <= w_rx;
      if (r_cnt == c_SMP1) r_smp1 <= w_rx;
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_idx       <= w_idx_nx;
      r_shift     <= w_shift_nx;
      r_arm       <= w_arm_nx;
      r_par_bit   <= w_par_bit_nx;
      r_stop_zero <= w_stop_zero_nx;
      r_stop_one  <= w_stop_one_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = w_cnt_end ? '0 : r_cnt + c_CW'(1);
    w_idx_nx       = r_idx;
    w_shift_nx     = r_shift;
    w_arm_nx       = r_arm;
    w_par_bit_nx   = r_par_bit;
    w_stop_zero_nx = r_stop_zero;
    w_stop_one_nx  = r_stop_one;
    w_done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        if (w_rx) begin
          w_arm_nx = 1'b1;
        end else if (r_arm) begin
          w_state_nx     = S_START;
          w_arm_nx       = 1'b0;
          w_idx_nx       = '0;
          w_shift_nx     = '0;
          w_par_bit_nx   = 1'b0;
          w_stop_zero_nx = 1'b0;
          w_stop_one_nx  = 1'b0;
        end
      end
      S_START: begin
        if (w_at_vote && w_vote) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end else if (w_cnt_end) begin
          w_state_nx = S_DATA;
        end
      end
      S_DATA: begin
        if (w_at_vote) begin
          for (int unsigned i = 0; i < p_DATA_BITS; i++) begin
            if (r_idx == c_IW'(i)) w_shift_nx[i] = w_vote;
          end
        end
        if (w_cnt_end) begin
          if (r_idx == c_LAST_DATA) begin
            w_idx_nx   = '0;
            w_state_nx = (p_PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            w_idx_nx = r_idx + c_IW'(1);
          end
        end
      end
      S_PARITY: begin
        if (w_at_vote) w_par_bit_nx = w_vote;
        if (w_cnt_end) w_state_nx = S_STOP;
      end
      S_STOP: begin
        if (w_at_vote) begin
          if (r_idx == c_LAST_STOP) begin
            w_done     = 1'b1;
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
          end else begin
            w_stop_zero_nx = r_stop_zero | ~w_vote;
            w_stop_one_nx  = r_stop_one | w_vote;
          end
        end else if (w_cnt_end) begin
          w_idx_nx = r_idx + c_IW'(1);
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_valid <= 1'b0;
      r_byte  <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_brk   <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (w_done) begin
        r_byte <= r_shift;
        r_perr <= w_perr;
        r_ferr <= w_ferr;
        r_brk  <= w_brk;
      end
    end
  end

  assign o_Rx_Valid   = r_valid;
  assign o_Rx_Byte    = r_byte;
  assign o_Parity_Err = r_perr;
  assign o_Frame_Err  = r_ferr;
  assign o_Break      = r_brk;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: default 8N1 instance at 217 clk/bit and a 9E2 instance at 19 clk/bit.
module tb_uart_rx_cfg;
  localparam int unsigned A_CPB = 217;
  localparam int unsigned B_CPB = 19;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic       va, pea, fea, bka;
  logic [7:0] byte_a;
  logic       vb, peb, feb, bkb;
  logic [8:0] byte_b;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned t_start[2];

  typedef struct {
    logic [8:0]  data;
    logic        perr;
    logic        ferr;
    logic        brk;
    int unsigned cyc;
  } t_obs;

  typedef struct {
    logic [8:0]  data;
    logic        pbit;
    logic [1:0]  stops;
    int unsigned gap;
    logic [8:0]  e_byte;
    logic        e_perr;
    logic        e_ferr;
    logic        e_brk;
  } t_vec;

  t_obs q_a[$];
  t_obs q_b[$];

  uart_rx_cfg u_dut_a (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Rx_UART(rx_a),
    .o_Rx_Valid(va), .o_Rx_Byte(byte_a), .o_Parity_Err(pea),
    .o_Frame_Err(fea), .o_Break(bka)
  );

  uart_rx_cfg #(.p_CLKs_PB(19), .p_DATA_BITS(9), .p_PARITY(2), .p_STOP_BITS(2)) u_dut_b (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Rx_UART(rx_b),
    .o_Rx_Valid(vb), .o_Rx_Byte(byte_b), .o_Parity_Err(peb),
    .o_Frame_Err(feb), .o_Break(bkb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (va) q_a.push_back('{data: {1'b0, byte_a}, perr: pea, ferr: fea, brk: bka, cyc: cyc});
    if (vb) q_b.push_back('{data: byte_b, perr: peb, ferr: feb, brk: bkb, cyc: cyc});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    if (n != 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int d, input logic v);
    if (d == 0) rx_a = v;
    else        rx_b = v;
  endtask

  function automatic int qsz(input int d);
    return (d == 0) ? q_a.size() : q_b.size();
  endfunction

  // Expected valid latency measured from the cycle the start bit is driven on the pin
  function automatic int unsigned lat(input int unsigned cpb, input int unsigned n);
    return 2 + (n - 1) * cpb + (cpb - 1) / 2 + 3;
  endfunction

  function automatic logic [15:0] frame(input logic [8:0] data, input int unsigned nd,
                                        input bit has_par, input logic pbit,
                                        input logic [1:0] stops, input int unsigned ns);
    logic [15:0] f;
    int unsigned p;
    f = '1;
    f[0] = 1'b0;
    p = 1;
    for (int unsigned i = 0; i < nd; i++) begin f[p] = data[i]; p++; end
    if (has_par) begin f[p] = pbit; p++; end
    for (int unsigned i = 0; i < ns; i++) begin f[p] = stops[i]; p++; end
    return f;
  endfunction

  // glitch inverts the pin for one cycle so the receiver's centre sample of every bit is wrong
  task automatic send_bits(input int d, input logic [15:0] bits, input int unsigned nb,
                           input int unsigned cpb, input bit glitch);
    int unsigned h;
    h = (cpb - 1) / 2;
    t_start[d] = cyc;
    for (int unsigned i = 0; i < nb; i++) begin
      drive(d, bits[i]);
      if (glitch) begin
        wait_cyc(h + 1);
        drive(d, ~bits[i]);
        wait_cyc(1);
        drive(d, bits[i]);
        wait_cyc(cpb - h - 2);
      end else begin
        wait_cyc(cpb);
      end
    end
  endtask

  task automatic expect_frame(input int d, input string nm, input logic [8:0] eb,
                              input logic ep, input logic ef, input logic ek,
                              input int unsigned elat);
    t_obs o;
    int unsigned w;
    w = 0;
    while (qsz(d) == 0 && w < 1000) begin wait_cyc(1); w++; end
    chk({nm, ".valid"}, 32'(qsz(d) != 0), 32'd1);
    if (qsz(d) != 0) begin
      if (d == 0) o = q_a.pop_front();
      else        o = q_b.pop_front();
      chk({nm, ".byte"}, 32'(o.data), 32'(eb));
      chk({nm, ".perr"}, 32'(o.perr), 32'(ep));
      chk({nm, ".ferr"}, 32'(o.ferr), 32'(ef));
      chk({nm, ".brk"},  32'(o.brk),  32'(ek));
      if (elat != 0) chk({nm, ".latency"}, o.cyc - t_start[d], elat);
    end
  endtask

  initial begin
    t_vec        vecs[8];
    logic [8:0]  d9;
    logic [7:0]  d8;
    logic        pb;
    logic [1:0]  st;
    logic [15:0] fb;
    int unsigned la, lb;

    // data, parity bit, {stop2,stop1}, idle gap, expected byte/perr/ferr/brk (even parity)
    vecs[0] = '{9'h007, 1'b1, 2'b11, 0,  9'h007, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{9'h007, 1'b0, 2'b11, 0,  9'h007, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{9'h1FF, 1'b1, 2'b11, 0,  9'h1FF, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{9'h155, 1'b0, 2'b01, 40, 9'h155, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{9'h000, 1'b0, 2'b00, 40, 9'h000, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{9'h000, 1'b1, 2'b00, 40, 9'h000, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{9'h0A0, 1'b0, 2'b10, 0,  9'h0A0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{9'h100, 1'b1, 2'b11, 0,  9'h100, 1'b0, 1'b0, 1'b0};
    la = lat(A_CPB, 10);
    lb = lat(B_CPB, 13);

    wait_cyc(3);
    chk("rst.a.valid", 32'(va), 32'd0);
    chk("rst.a.byte",  32'(byte_a), 32'd0);
    chk("rst.a.perr",  32'(pea), 32'd0);
    chk("rst.a.ferr",  32'(fea), 32'd0);
    chk("rst.a.brk",   32'(bka), 32'd0);
    chk("rst.b.valid", 32'(vb), 32'd0);
    chk("rst.b.byte",  32'(byte_b), 32'd0);
    rst_n = 1'b1;
    wait_cyc(5);

    send_bits(0, frame(9'h0A5, 8, 1'b0, 1'b0, 2'b11, 1), 10, A_CPB, 1'b0);
    expect_frame(0, "a.A5", 9'h0A5, 1'b0, 1'b0, 1'b0, la);

    for (int i = 0; i < 8; i++) begin
      send_bits(1, frame(vecs[i].data, 9, 1'b1, vecs[i].pbit, vecs[i].stops, 2), 13, B_CPB, 1'b0);
      expect_frame(1, $sformatf("b.vec%0d", i), vecs[i].e_byte, vecs[i].e_perr,
                   vecs[i].e_ferr, vecs[i].e_brk, lb);
      drive(1, 1'b1);
      wait_cyc(vecs[i].gap);
    end

    for (int i = 0; i < 30; i++) begin
      d9 = 9'($urandom);
      pb = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      send_bits(1, frame(d9, 9, 1'b1, pb, st, 2), 13, B_CPB, 1'b0);
      expect_frame(1, $sformatf("b.rnd%0d", i), d9,
                   1'((($countones(d9) + int'(pb)) % 2) != 0),
                   1'(st != 2'b11),
                   1'((d9 == 9'd0) && !pb && (st == 2'b00)), lb);
      drive(1, 1'b1);
      wait_cyc(st[1] ? $urandom_range(0, 3) : 2 * B_CPB);
    end

    for (int i = 0; i < 4; i++) begin
      d8 = 8'($urandom);
      send_bits(0, frame({1'b0, d8}, 8, 1'b0, 1'b0, 2'b11, 1), 10, A_CPB, 1'b0);
      expect_frame(0, $sformatf("a.rnd%0d", i), {1'b0, d8}, 1'b0, 1'b0, 1'b0, la);
      wait_cyc($urandom_range(0, 2));
    end

    drive(0, 1'b0);
    wait_cyc(50);
    drive(0, 1'b1);
    wait_cyc(3 * A_CPB);
    chk("a.falsestart.none", qsz(0), 32'd0);
    send_bits(0, frame(9'h03C, 8, 1'b0, 1'b0, 2'b11, 1), 10, A_CPB, 1'b0);
    expect_frame(0, "a.3C", 9'h03C, 1'b0, 1'b0, 1'b0, la);

    send_bits(0, frame(9'h055, 8, 1'b0, 1'b0, 2'b11, 1), 10, A_CPB, 1'b1);
    expect_frame(0, "a.glitch55", 9'h055, 1'b0, 1'b0, 1'b0, la);

    drive(0, 1'b0);
    t_start[0] = cyc;
    wait_cyc(12 * A_CPB);
    chk("a.break.count", qsz(0), 32'd1);
    expect_frame(0, "a.break", 9'h000, 1'b0, 1'b1, 1'b1, la);
    drive(0, 1'b1);
    wait_cyc(2 * A_CPB);
    send_bits(0, frame(9'h081, 8, 1'b0, 1'b0, 2'b11, 1), 10, A_CPB, 1'b0);
    expect_frame(0, "a.81", 9'h081, 1'b0, 1'b0, 1'b0, la);

    // Reset during data bit 4 of a frame; outputs currently hold 0x81
    fb = frame(9'h05A, 8, 1'b0, 1'b0, 2'b11, 1);
    for (int unsigned i = 0; i < 5; i++) begin
      drive(0, fb[i]);
      wait_cyc(A_CPB);
    end
    drive(0, fb[5]);
    wait_cyc(100);
    rst_n = 1'b0;
    #1;
    chk("a.midrst.valid", 32'(va), 32'd0);
    chk("a.midrst.byte",  32'(byte_a), 32'd0);
    chk("a.midrst.perr",  32'(pea), 32'd0);
    chk("a.midrst.ferr",  32'(fea), 32'd0);
    chk("a.midrst.brk",   32'(bka), 32'd0);
    drive(0, 1'b1);
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(12 * A_CPB);
    chk("a.midrst.novalid", qsz(0), 32'd0);
    send_bits(0, frame(9'h0C3, 8, 1'b0, 1'b0, 2'b11, 1), 10, A_CPB, 1'b0);
    expect_frame(0, "a.C3", 9'h0C3, 1'b0, 1'b0, 1'b0, la);

    wait_cyc(2 * A_CPB);
    chk("end.a.extra", qsz(0), 32'd0);
    chk("end.b.extra", qsz(1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
